// File: rtl/alu_result_stage.sv
// alu_result_stage: pipeline register after the fault-tolerant ALU.
// The captured {zero, result} word is held in four redundant lanes and
// bitwise majority-voted on the output. A lane that disagrees with the vote
// on a transfer is retired for good. The stage halts when fewer than two
// lanes remain in service.
// Optional feature macro: ALU_STAGE_FAULT_COUNT_EN adds per-lane fault
// counters (fault_cnt) and a tie counter (tie_cnt).
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_zero,
  input  logic             inj_en,
  input  logic [1:0]       inj_lane,
  input  logic [WIDTH:0]   inj_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic [3:0]       lane_en,
  output logic             uncorr,
  output logic             halted
`ifdef ALU_STAGE_FAULT_COUNT_EN
  ,
  output logic [4*CNT_W-1:0] fault_cnt,
  output logic [CNT_W-1:0]   tie_cnt
`endif
);

  localparam int LW = WIDTH + 1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] lane_q [4];
  logic [LW-1:0] lane_d [4];
  logic [3:0]    en_q, en_d;
  logic          uncorr_q, uncorr_d;

  logic [LW-1:0] vote_s;
  logic          tie_s;
  logic [3:0]    diff_s;
  logic [2:0]    n_en_s;
  logic          xfer_s;
  logic          cap_s;

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    popcnt4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  assign n_en_s = popcnt4(en_q);

  // Bitwise vote over enabled lanes; a bit is a tie when ones equal zeros.
  always_comb begin
    vote_s = '0;
    tie_s  = 1'b0;
    for (int b = 0; b < LW; b++) begin
      vote_s[b] = popcnt4(en_q & {lane_q[3][b], lane_q[2][b], lane_q[1][b], lane_q[0][b]}) >= 3'd2;
      if ({popcnt4(en_q & {lane_q[3][b], lane_q[2][b], lane_q[1][b], lane_q[0][b]}), 1'b0} == {1'b0, n_en_s}) begin
        tie_s = 1'b1;
      end else begin
        tie_s = tie_s;
      end
    end
  end

  // Flag every enabled lane whose stored copy disagrees with the vote.
  always_comb begin
    diff_s = 4'b0000;
    for (int l = 0; l < 4; l++) begin
      diff_s[l] = en_q[l] && (lane_q[l] != vote_s);
    end
  end

  assign in_ready   = (state_q == ST_EMPTY) || ((state_q == ST_FULL) && out_ready);
  assign xfer_s     = (state_q == ST_FULL) && out_ready;
  assign cap_s      = in_valid && in_ready;
  assign out_valid  = (state_q == ST_FULL);
  assign out_result = (state_q == ST_FULL) ? vote_s[WIDTH-1:0] : '0;
  assign out_zero   = (state_q == ST_FULL) ? vote_s[WIDTH] : 1'b0;
  assign lane_en    = en_q;
  assign uncorr     = uncorr_q;
  assign halted     = (state_q == ST_HALT);

  // Next-state: retirement from the old lanes, capture into all lanes, FSM.
  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    uncorr_d = 1'b0;
    for (int l = 0; l < 4; l++) begin
      lane_d[l] = lane_q[l];
    end

    if (xfer_s) begin
      if (tie_s) begin
        uncorr_d = 1'b1;
      end else begin
        en_d = en_q & ~diff_s;
      end
    end else begin
      en_d = en_q;
    end

    if (cap_s) begin
      for (int l = 0; l < 4; l++) begin
        lane_d[l] = {in_zero, in_result} ^ ((inj_en && (inj_lane == 2'(l))) ? inj_mask : {LW{1'b0}});
      end
    end else begin
      uncorr_d = uncorr_d;
    end

    case (state_q)
      ST_EMPTY: state_d = cap_s ? ST_FULL : ST_EMPTY;
      ST_FULL: begin
        if (cap_s) begin
          state_d = ST_FULL;
        end else if (xfer_s) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_FULL;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase

    if (popcnt4(en_d) < 3'd2) begin
      state_d = ST_HALT;
    end else begin
      state_d = state_d;
    end
  end

  // State, lane copies, lane enables and the tie pulse register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      en_q     <= 4'b1111;
      uncorr_q <= 1'b0;
      for (int l = 0; l < 4; l++) begin
        lane_q[l] <= '0;
      end
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      uncorr_q <= uncorr_d;
      for (int l = 0; l < 4; l++) begin
        lane_q[l] <= lane_d[l];
      end
    end
  end

`ifdef ALU_STAGE_FAULT_COUNT_EN
  logic [CNT_W-1:0] fc_q [4];
  logic [CNT_W-1:0] tie_q;

  // Saturating per-lane disagreement counters and tie-pulse counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      tie_q <= '0;
      for (int l = 0; l < 4; l++) begin
        fc_q[l] <= '0;
      end
    end else begin
      if (uncorr_q && (tie_q != {CNT_W{1'b1}})) begin
        tie_q <= tie_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      for (int l = 0; l < 4; l++) begin
        if (xfer_s && diff_s[l] && (fc_q[l] != {CNT_W{1'b1}})) begin
          fc_q[l] <= fc_q[l] + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  // Pack the lane counters onto the flat output bus.
  always_comb begin
    fault_cnt = '0;
    for (int l = 0; l < 4; l++) begin
      fault_cnt[l*CNT_W +: CNT_W] = fc_q[l];
    end
  end

  assign tie_cnt = tie_q;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios with literal
// expectations followed by randomized traffic, all checked every cycle
// against a behavioural lane/vote model.
module tb_alu_result_stage;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_zero, inj_en, out_ready;
  logic [W-1:0]  in_result;
  logic [1:0]    inj_lane;
  logic [W:0]    inj_mask;
  logic          in_ready, out_valid, out_zero, uncorr, halted;
  logic [W-1:0]  out_result;
  logic [3:0]    lane_en;
`ifdef ALU_STAGE_FAULT_COUNT_EN
  logic [31:0]   fault_cnt;
  logic [7:0]    tie_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [W:0]    m_lane [4];
  logic [3:0]    m_en;
  bit            m_full, m_halt, m_uncorr;
  int            m_fc [4];
  int            m_tie;

  alu_result_stage #(.WIDTH(W), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_zero(in_zero),
    .inj_en(inj_en), .inj_lane(inj_lane), .inj_mask(inj_mask),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero),
    .lane_en(lane_en), .uncorr(uncorr), .halted(halted)
`ifdef ALU_STAGE_FAULT_COUNT_EN
    , .fault_cnt(fault_cnt), .tie_cnt(tie_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Majority per bit among enabled lanes; tie when ones == zeros.
  function automatic void m_vote(output logic [W:0] v, output bit tie);
    int n, ones;
    n = $countones(m_en);
    v = '0;
    tie = 0;
    for (int b = 0; b <= W; b++) begin
      ones = 0;
      for (int l = 0; l < 4; l++) if (m_en[l] && m_lane[l][b]) ones++;
      if (ones >= 2) v[b] = 1'b1;
      if (2 * ones == n) tie = 1;
    end
  endfunction

  function automatic bit m_ready();
    return !m_halt && (!m_full || out_ready);
  endfunction

  // Advance the model by one clock edge using the current inputs.
  task automatic model_step();
    logic [W:0] v;
    logic [3:0] ne;
    bit tie, xfer, cap;
    if (reset) begin
      for (int l = 0; l < 4; l++) begin m_lane[l] = '0; m_fc[l] = 0; end
      m_en = 4'b1111; m_full = 0; m_halt = 0; m_uncorr = 0; m_tie = 0;
    end else begin
      if (m_uncorr && m_tie < 255) m_tie++;
      xfer = m_full && !m_halt && out_ready;
      cap  = in_valid && m_ready();
      m_vote(v, tie);
      ne = m_en;
      m_uncorr = 0;
      if (xfer) begin
        for (int l = 0; l < 4; l++)
          if (m_en[l] && m_lane[l] != v) begin
            if (!tie) ne[l] = 1'b0;
            if (m_fc[l] < 255) m_fc[l]++;
          end
        m_uncorr = tie;
      end
      if (cap)
        for (int l = 0; l < 4; l++)
          m_lane[l] = {in_zero, in_result} ^ ((inj_en && inj_lane == l) ? inj_mask : '0);
      m_en = ne;
      if ($countones(ne) < 2) m_halt = 1;
      else if (cap) m_full = 1;
      else if (xfer) m_full = 0;
    end
  endtask

  // Compare every observable output with the model.
  task automatic compare_all();
    logic [W:0] v;
    bit tie;
    m_vote(v, tie);
    chk("out_valid", out_valid, m_full && !m_halt);
    chk("lane_en", lane_en, m_en);
    chk("uncorr", uncorr, m_uncorr);
    chk("halted", halted, m_halt);
    if (m_full && !m_halt) begin
      chk("out_result", out_result, v[W-1:0]);
      chk("out_zero", out_zero, v[W]);
    end
`ifdef ALU_STAGE_FAULT_COUNT_EN
    for (int l = 0; l < 4; l++) chk("fault_cnt", fault_cnt[l*8 +: 8], m_fc[l]);
    chk("tie_cnt", tie_cnt, m_tie);
`endif
  endtask

  task automatic tick();
    #1;
    chk("in_ready", in_ready, m_ready());
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input bit v, input logic [W-1:0] d, input bit rdy,
                       input bit ie, input logic [1:0] il, input logic [W:0] im);
    in_valid = v; in_result = d; in_zero = (d == '0); out_ready = rdy;
    inj_en = ie; inj_lane = il; inj_mask = im;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, '0, 0, 0, 2'd0, '0);
    @(negedge clk);
    tick();
    reset = 1'b0;
    tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_lane_en", lane_en, 4'b1111);
    chk("rst_halted", halted, 1'b0);
    chk("rst_out_result", out_result, 32'h0);
    chk("rst_in_ready", in_ready, 1'b1);

    // First capture and back-to-back stream
    drive(1, 32'h0000_00A5, 1, 0, 2'd0, '0);
    tick();
    chk("a5_valid", out_valid, 1'b1);
    chk("a5_result", out_result, 32'h0000_00A5);
    for (int i = 1; i <= 3; i++) begin
      drive(1, 32'(i), 1, 0, 2'd0, '0);
      tick();
      chk("b2b_valid", out_valid, 1'b1);
      chk("b2b_result", out_result, 32'(i));
    end

    // Stall with a pending input, then release
    drive(1, 32'h55, 0, 0, 2'd0, '0);
    #1;
    chk("stall_in_ready", in_ready, 1'b0);
    tick();
    chk("stall_hold", out_result, 32'h3);
    drive(1, 32'h55, 1, 0, 2'd0, '0);
    tick();
    chk("release_result", out_result, 32'h55);
    drive(0, '0, 1, 0, 2'd0, '0);
    tick();
    chk("drain_valid", out_valid, 1'b0);

    // Single-lane fault in lane 2
    drive(1, 32'hFFFF_0000, 0, 1, 2'd2, 33'h1);
    tick();
    chk("inj2_result", out_result, 32'hFFFF_0000);
    drive(0, '0, 1, 0, 2'd0, '0);
    tick();
    chk("inj2_lane_en", lane_en, 4'b1011);
    chk("inj2_uncorr", uncorr, 1'b0);

    // Fault in lane 0 with three lanes left
    drive(1, 32'hFFFF_0000, 0, 1, 2'd0, 33'h1);
    tick();
    chk("inj0_result", out_result, 32'hFFFF_0000);
    drive(0, '0, 1, 0, 2'd0, '0);
    tick();
    chk("inj0_lane_en", lane_en, 4'b1010);

    // 1-1 tie with two lanes left
    drive(1, 32'h0, 0, 1, 2'd1, 33'h1);
    tick();
    chk("tie_result", out_result, 32'h0);
    drive(0, '0, 1, 0, 2'd0, '0);
    tick();
    chk("tie_uncorr", uncorr, 1'b1);
    chk("tie_lane_en", lane_en, 4'b1010);
    chk("tie_halted", halted, 1'b0);
    tick();
    chk("tie_uncorr_end", uncorr, 1'b0);

    // Reset restores all lanes
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rerst_lane_en", lane_en, 4'b1111);
    chk("rerst_halted", halted, 1'b0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      logic [W:0] mk;
      logic [W-1:0] d;
      mk = ($urandom % 2 == 0) ? (33'h1 << ($urandom % 33)) : {1'($urandom), 32'($urandom)};
      case ($urandom % 4)
        0: d = '0;
        1: d = 32'hFFFF_FFFF;
        default: d = $urandom;
      endcase
      reset = ($urandom % 250 == 0);
      drive($urandom % 4 != 0, d, $urandom % 3 != 0, $urandom % 6 == 0, 2'($urandom), mk);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
